// File: rtl/game_score_keeper_if.sv
// +----------------------------------------------------------------------+
// | Module   : game_score_keeper_if                                      |
// | Brief    : Game clock, session controls and score outputs bundled    |
// |            between the game-clock source and the score keeper.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface game_score_keeper_if;
  logic        game_clk;
  logic        start;
  logic        crash;
  logic        tick;
  logic [1:0]  state;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        new_record;

  modport master (
    output game_clk, start, crash,
    input  tick, state, score, hi_score, new_record
  );

  modport slave (
    input  game_clk, start, crash,
    output tick, state, score, hi_score, new_record
  );
endinterface

`default_nettype wire

// File: rtl/game_score_keeper.sv
// +----------------------------------------------------------------------+
// | Module   : game_score_keeper                                         |
// | Brief    : Synchronizes the divided game clock into clk as one-cycle |
// |            ticks, runs the IDLE/RUN/OVER session FSM and keeps a     |
// |            saturating 4-digit BCD score. Optional high-score register|
// |            and new_record flag are built when GAME_HIGH_SCORE_EN is  |
// |            defined; otherwise hi_score/new_record are tied to zero.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module game_score_keeper #(
  parameter int SCORE_DIV = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  game_score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [7:0]  c_DIV_LAST = 8'(SCORE_DIV - 1);
  localparam logic [15:0] c_SCORE_MAX = 16'h9999;

  logic        r_s1;
  logic        r_s2;
  logic        r_p;
  state_t      r_state;
  logic        r_tick;
  logic [15:0] r_score;
  logic [7:0]  r_sub;

  logic        w_rise;
  logic        w_start_game;
  logic        w_end_game;
  logic [15:0] w_score_inc;
  logic        w_carry;

  assign w_rise       = r_s2 & ~r_p;
  assign w_start_game = bus.start && (r_state != ST_RUN);
  assign w_end_game   = bus.crash && (r_state == ST_RUN);

  // Two-flop synchronizer plus previous-value flop for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= bus.game_clk;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  // Ripple-carry BCD increment; holds at 9999 instead of wrapping
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_score[i*4 +: 4] == 4'd9) begin
          w_score_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_score_inc[i*4 +: 4] = r_score[i*4 +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
    if (r_score == c_SCORE_MAX) begin
      w_score_inc = r_score;
    end
  end

  // Session FSM with registered tick, score and sub-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tick  <= 1'b0;
      r_score <= 16'h0000;
      r_sub   <= 8'd0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_score <= 16'h0000;
            r_sub   <= 8'd0;
          end
        end
        ST_RUN: begin
          // crash wins over a coincident rise: no tick, score frozen
          if (bus.crash) begin
            r_state <= ST_OVER;
          end else if (w_rise) begin
            r_tick <= 1'b1;
            if (r_sub == c_DIV_LAST) begin
              r_sub   <= 8'd0;
              r_score <= w_score_inc;
            end else begin
              r_sub <= r_sub + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tick  = r_tick;
  assign bus.state = r_state;
  assign bus.score = r_score;

`ifdef GAME_HIGH_SCORE_EN
  logic [15:0] r_hi_score;
  logic        r_new_record;

  // Capture a better score at game end; BCD words compare correctly as binary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_score   <= 16'h0000;
      r_new_record <= 1'b0;
    end else if (w_end_game) begin
      if (r_score > r_hi_score) begin
        r_hi_score   <= r_score;
        r_new_record <= 1'b1;
      end
    end else if (w_start_game) begin
      r_new_record <= 1'b0;
    end
  end

  assign bus.hi_score   = r_hi_score;
  assign bus.new_record = r_new_record;
`else
  assign bus.hi_score   = 16'h0000;
  assign bus.new_record = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_score_keeper.sv
// +----------------------------------------------------------------------+
// | Module   : tb_game_score_keeper                                      |
// | Brief    : Scoreboard bench for game_score_keeper. Instance A uses   |
// |            SCORE_DIV=10 for session/crash/high-score behaviour,      |
// |            instance B uses SCORE_DIV=1 for BCD carry and saturation. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_game_score_keeper;

`ifdef GAME_HIGH_SCORE_EN
  localparam bit c_HS_EN = 1'b1;
`else
  localparam bit c_HS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  game_score_keeper_if a_if();
  game_score_keeper_if b_if();

  game_score_keeper #(.SCORE_DIV(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  game_score_keeper #(.SCORE_DIV(1))  u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int na     = 0;
  int nb     = 0;

  typedef struct {
    int          cyc;
    logic [15:0] score;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor A: every tick must match the oldest expected tick
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_if.tick === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_tick: got unexpected tick at cycle %0d, expected none", cyc);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || a_if.score !== e.score) begin
          errors++;
          $display("FAIL a_tick: got cycle %0d score %h, expected cycle %0d score %h",
                   cyc, a_if.score, e.cyc, e.score);
        end
      end
    end
  end

  // Monitor B: same for the SCORE_DIV=1 instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_if.tick === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_tick: got unexpected tick at cycle %0d, expected none", cyc);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || b_if.score !== e.score) begin
          errors++;
          $display("FAIL b_tick: got cycle %0d score %h, expected cycle %0d score %h",
                   cyc, b_if.score, e.cyc, e.score);
        end
      end
    end
  end

  // Rise driven at negedge N is first sampled at posedge N+1; tick is seen at N+3
  task automatic rise_a(input int hi, input int lo);
    exp_t e;
    @(negedge clk);
    a_if.game_clk = 1'b1;
    na++;
    e.cyc   = cyc + 3;
    e.score = to_bcd(na / 10);
    qa.push_back(e);
    repeat (hi) @(negedge clk);
    a_if.game_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rise_b();
    exp_t e;
    @(negedge clk);
    b_if.game_clk = 1'b1;
    nb++;
    e.cyc   = cyc + 3;
    e.score = to_bcd(nb);
    qb.push_back(e);
    repeat (2) @(negedge clk);
    b_if.game_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
  endtask

  task automatic pulse_crash_a();
    @(negedge clk);
    a_if.crash = 1'b1;
    @(negedge clk);
    a_if.crash = 1'b0;
  endtask

  initial begin
    a_if.game_clk = 1'b0; a_if.start = 1'b0; a_if.crash = 1'b0;
    b_if.game_clk = 1'b0; b_if.start = 1'b0; b_if.crash = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", {14'b0, a_if.state}, 16'h0000);
    chk("reset_score", a_if.score, 16'h0000);
    chk("reset_hi", a_if.hi_score, 16'h0000);
    chk("reset_tick_nr", {14'b0, a_if.tick, a_if.new_record}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Crash in IDLE is ignored
    pulse_crash_a();
    chk("idle_crash_state", {14'b0, a_if.state}, 16'h0000);

    // Game 1: 25 rises at period 20, then fast rises up to 370 total
    pulse_start_a();
    na = 0;
    chk("start_state", {14'b0, a_if.state}, 16'h0001);
    for (int i = 0; i < 25; i++) rise_a(10, 9);
    repeat (4) @(negedge clk);
    chk("score_25", a_if.score, 16'h0002);
    for (int i = 0; i < 345; i++) rise_a(2, 1);
    repeat (4) @(negedge clk);
    chk("score_370", a_if.score, 16'h0037);

    // Crash coincident with rise: no tick, score frozen, record captured
    @(negedge clk);
    a_if.game_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_if.crash = 1'b1;
    @(negedge clk);
    a_if.crash = 1'b0;
    chk("crash_state", {14'b0, a_if.state}, 16'h0002);
    chk("crash_score", a_if.score, 16'h0037);
    chk("crash_hi", a_if.hi_score, c_HS_EN ? 16'h0037 : 16'h0000);
    chk("crash_nr", {15'b0, a_if.new_record}, {15'b0, c_HS_EN});
    repeat (2) @(negedge clk);
    a_if.game_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("over_no_tick_score", a_if.score, 16'h0037);

    // Crash in OVER ignored
    pulse_crash_a();
    chk("over_crash_state", {14'b0, a_if.state}, 16'h0002);

    // Game 2: lower score, hi_score kept
    pulse_start_a();
    na = 0;
    chk("restart_state", {14'b0, a_if.state}, 16'h0001);
    chk("restart_score", a_if.score, 16'h0000);
    chk("restart_nr", {15'b0, a_if.new_record}, 16'h0000);
    chk("restart_hi", a_if.hi_score, c_HS_EN ? 16'h0037 : 16'h0000);
    for (int i = 0; i < 125; i++) rise_a(2, 1);
    repeat (4) @(negedge clk);
    pulse_start_a();
    chk("run_start_state", {14'b0, a_if.state}, 16'h0001);
    chk("run_start_score", a_if.score, 16'h0012);
    for (int i = 0; i < 5; i++) rise_a(2, 1);
    repeat (4) @(negedge clk);
    chk("run_start_sub_kept", a_if.score, 16'h0013);
    pulse_crash_a();
    chk("game2_state", {14'b0, a_if.state}, 16'h0002);
    chk("game2_hi", a_if.hi_score, c_HS_EN ? 16'h0037 : 16'h0000);
    chk("game2_nr", {15'b0, a_if.new_record}, 16'h0000);

    // Instance B: BCD carry and saturation with one point per tick
    @(negedge clk);
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    nb = 0;
    for (int i = 0; i < 100; i++) rise_b();
    repeat (4) @(negedge clk);
    chk("b_score_100", b_if.score, 16'h0100);
    for (int i = 100; i < 9999; i++) rise_b();
    repeat (4) @(negedge clk);
    chk("b_score_9999", b_if.score, 16'h9999);
    for (int i = 0; i < 5; i++) rise_b();
    repeat (4) @(negedge clk);
    chk("b_score_sat", b_if.score, 16'h9999);

    // Game 3 on A reaches 42, then asynchronous reset mid-game
    pulse_start_a();
    na = 0;
    for (int i = 0; i < 420; i++) rise_a(2, 1);
    repeat (4) @(negedge clk);
    chk("score_420", a_if.score, 16'h0042);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {14'b0, a_if.state}, 16'h0000);
    chk("async_rst_score", a_if.score, 16'h0000);
    chk("async_rst_hi", a_if.hi_score, 16'h0000);
    chk("async_rst_tick_nr", {14'b0, a_if.tick, a_if.new_record}, 16'h0000);
    chk("async_rst_b_score", b_if.score, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("qa_drained", 16'(qa.size()), 16'h0000);
    chk("qb_drained", 16'(qb.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_score_keeper.md
# game_score_keeper

Receiving end of the game clock. It takes the divided, speed-ramping game clock, which is a square wave generated elsewhere from `clk`, and brings it back into the `clk` domain as single-cycle tick pulses. It runs the game-session state machine (idle / running / over) and keeps a 4-digit BCD score plus an optional high score for the display path.

## Interface
- `SCORE_DIV`, default 10: game ticks per score point; legal range 1..255.
- `clk` in 1: system clock. All logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `game_clk` in 1: divided game clock.
  - Treated as asynchronous.
  - Only rising edges are significant.
- `start` in 1: one-cycle pulse (already debounced/one-pulsed upstream) that begins a game.
- `crash` in 1: level, sampled every cycle; ends the game while running.
- `tick` out 1: one-cycle pulse per `game_clk` rising edge, only while RUN.
- `state` out 2: encoding is 2'b00 IDLE, 2'b01 RUN, 2'b10 OVER; 2'b11 is unused.
- `score` out 16: current score, 4 BCD digits, `[15:12]` is the most significant digit.
- `hi_score` out 16: best score since reset, BCD.
- `new_record` out 1: high in OVER when the last game set a new high score.

## Operation
- **Synchronizer:** 2 flops (`s1`, `s2`) plus a previous-value flop `p`, all reset to 0.
  - `rise = s2 & ~p`.
- **State machine:**
  - IDLE:
    - `start` → RUN.
    - On that edge, clear `score`, the sub-counter and `new_record`.
  - RUN:
    - `crash` → OVER. Crash has priority over `rise` and `start` in the same cycle: no tick, no score change.
    - Otherwise on `rise`: `tick` is set and the sub-counter is incremented.
    - When the sub-counter equals `SCORE_DIV-1`, it is cleared and `score` is incremented by one.
  - OVER:
    - `score` and `hi_score` are held.
    - `start` → RUN, with the same clears as from IDLE.
    - `crash` is ignored.
- **High score:** on the RUN→OVER edge, if `score > hi_score` (compared as plain binary on the BCD word, which is order-preserving):
  - `hi_score <= score`;
  - `new_record <= 1`.
  - Otherwise `new_record` stays 0.
- **Sub-counter:** 8 bits; it is not cleared on crash, only on start.
- **BCD increment:**
  - Ripple carry: a digit at 9 wraps to 0 and carries into the next digit.
  - The score saturates at 16'h9999; further point events leave it unchanged.
- **Start in RUN:** ignored.

## Timing
- **Reset values:** `tick`=0, `state`=IDLE, `score`=0, `hi_score`=0, `new_record`=0. Reset is asynchronous.
- **Tick latency:** if `game_clk` is first sampled high at clk edge E0, `rise` is true after E1, and `tick` and the score update are registered at E2. `tick` is high exactly one cycle, E2 to E3.
- **Edge rate:** each `game_clk` rising edge yields at most one tick, provided `game_clk` stays high and low for at least 2 `clk` cycles each.
- **State change:** occurs at the first clk edge at which `start`/`crash` is sampled. Outputs are registered; there are no combinational paths from inputs to outputs.
- **After reset release:** if `game_clk` is high at release, a `rise` is seen. The block is in IDLE, so no tick and no effect.
- **Reset mid-game:** all state, including `hi_score`, clears immediately.

## Configuration
- `GAME_HIGH_SCORE_EN` defined: high-score register and `new_record` behave as above.
- `GAME_HIGH_SCORE_EN` undefined:
  - The high-score register and comparator are not built.
  - `hi_score` is tied to 16'h0000 and `new_record` to 0.
  - All other behaviour is identical.

## Test plan
- **Reset:** drive `rst_n`=0 mid-RUN with `score`=16'h0042 → all outputs 0 and `state`=00 without waiting for a clk edge.
- **Tick and score:** `SCORE_DIV`=10; `start` pulse, then 25 `game_clk` rising edges (period 20 clk) → 25 one-cycle `tick` pulses, each 2 clk edges after the sampled rise; `score`=16'h0002.
- **BCD carry and saturation:** `SCORE_DIV`=1; 100 rises → `score`=16'h0100; 9999 total rises → 16'h9999; 5 more rises → still 16'h9999, and `tick` still pulses.
- **Crash with tick:** `crash` in the same cycle as `rise`, with `score`=16'h0037 and `hi_score`=0 → `state`=10, no tick, `score`=16'h0037, `hi_score`=16'h0037, `new_record`=1.
- **Lower second game:** `start` in OVER → `score`=0, `new_record`=0, `state`=01; crash at `score`=16'h0012 → `hi_score` stays 16'h0037 and `new_record`=0. With `GAME_HIGH_SCORE_EN` undefined, `hi_score` is 0 throughout.
- **Ignored inputs:** `start` in RUN and `crash` in OVER/IDLE → no state change and `score` unchanged.
